// File: rtl/grf_pkg.sv
// Shared constants, scoreboard operation type and write-log format for the multiport GRF.
// The write log is compiled only when GRF_WRITE_LOG_EN is defined.
package grf_pkg;

  localparam int GRF_DW = 32;
  localparam int GRF_AW = 5;
  localparam int GRF_NR = 2;
  localparam int GRF_CW = 2;

  localparam int GRF_ZERO_REG = 0;

  // Timestamp, then PC, destination register and written value.
  localparam string GRF_LOG_FMT = "%0t@%08h: $%2d <= %08h";

  typedef enum logic [1:0] {
    SB_HOLD = 2'd0,
    SB_INC  = 2'd1,
    SB_DEC  = 2'd2
  } sb_op_e;

  // An issue and a retire on the same register cancel out.
  function automatic sb_op_e sbDecode(input logic inc, input logic dec);
    sb_op_e op;
    op = SB_HOLD;
    if (inc && !dec) begin
      op = SB_INC;
    end else if (dec && !inc) begin
      op = SB_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/grf_sb_counter.sv
// One saturating up/down pending-write counter with a sticky error flag.
// An increment at max or a decrement at zero leaves the count alone and raises the flag.
module grf_sb_counter
  import grf_pkg::*;
#(
  parameter int CW = GRF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_err
);

  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] r_count;
  logic          r_err;
  sb_op_e        w_op;

  always_comb begin
    w_op = sbDecode(i_inc, i_dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (w_op)
        SB_INC: begin
          if (r_count == CMAX) begin
            r_err <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        SB_DEC: begin
          if (r_count == '0) begin
            r_err <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/grf_multiport.sv
// Pipelined-MIPS general register file: NR combinational read ports, one write port,
// optional write-to-read bypass, hardwired $0 and a per-register pending-write scoreboard.
// Defining GRF_WRITE_LOG_EN prints one line per effective write.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DW     = GRF_DW,
  parameter int AW     = GRF_AW,
  parameter int NR     = GRF_NR,
  parameter int BYPASS = 1,
  parameter int CW     = GRF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rbusy,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [31:0]      wpc,
  input  logic             issue,
  input  logic [AW-1:0]    issue_addr,
  input  logic             retire,
  input  logic [AW-1:0]    retire_addr,
  output logic             sb_err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(GRF_ZERO_REG);

  logic [DW-1:0] r_regs [DEPTH];
  logic [CW-1:0] w_count [DEPTH];
  logic [DEPTH-1:0] w_err;
  logic          w_writeEn;

  assign w_writeEn = we && (waddr != ZERO_ADDR);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeEn) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_count[0] = '0;
  assign w_err[0]   = 1'b0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_sb
    logic w_inc;
    logic w_dec;

    assign w_inc = issue && (issue_addr == AW'(g));
    assign w_dec = retire && (retire_addr == AW'(g));

    grf_sb_counter #(
      .CW(CW)
    ) u_counter (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (w_inc),
      .i_dec  (w_dec),
      .o_count(w_count[g]),
      .o_err  (w_err[g])
    );
  end

  assign sb_err = |w_err;

  // Reads are forced to zero during reset so a pending bypass cannot leak through.
  always_comb begin
    logic [AW-1:0] w_ra;
    rdata = '0;
    rbusy = '0;
    w_ra  = '0;
    for (int p = 0; p < NR; p++) begin
      w_ra = raddr[p*AW +: AW];
      if (!reset && (w_ra != ZERO_ADDR)) begin
        if ((BYPASS != 0) && we && (waddr == w_ra)) begin
          rdata[p*DW +: DW] = wdata;
        end else begin
          rdata[p*DW +: DW] = r_regs[w_ra];
        end
        rbusy[p] = (w_count[w_ra] != '0);
      end
    end
  end

`ifdef GRF_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && w_writeEn) begin
      $display(GRF_LOG_FMT, $time, wpc, waddr, wdata);
    end
  end
`else
  logic w_unused_wpc;
  assign w_unused_wpc = ^wpc;
`endif

endmodule
